// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and latency constants shared by decode, execute and the mul/div unit.
package muldiv_pkg;
    localparam int MD_MUL_CYCLES  = 2;
    localparam int MD_DIV_ITERS   = 32;
    localparam int MD_DIV_LATENCY = MD_DIV_ITERS + 2;

    typedef enum logic [2:0] {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;
    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} md_state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage request/hazard bundle between the pipeline (master) and the mul/div unit (slave).
interface muldiv_if;
    import muldiv_pkg::*;
    logic        valid;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        flush;
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output valid, op, a, b, stall, flush, input ok, hi, lo);
    modport slave  (input valid, op, a, b, stall, flush, output ok, hi, lo);
endinterface

// File: rtl/div_core.sv
// div_core: iterative restoring unsigned divider, one quotient bit per cycle.
// The first step is taken on the start edge itself, so busy covers the remaining ITERS-1 steps.
module div_core #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(ITERS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, src_rem, src_quo;
    logic [32:0]   shifted, diff;
    logic          step;

    assign busy    = cnt_q != '0;
    assign step    = start || busy;
    assign src_rem = start ? '0 : rem_q;
    assign src_quo = start ? dividend : quo_q;
    assign dvs_d   = start ? divisor : dvs_q;
    assign shifted = {src_rem, src_quo[31]};
    assign diff    = shifted - {1'b0, dvs_d};
    assign rem_d   = !step ? rem_q : diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_d   = !step ? quo_q : {src_quo[30:0], !diff[32]};
    assign cnt_d   = kill ? '0 : start ? CW'(ITERS - 1) : busy ? cnt_q - CW'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine; holds ok low while an op is in flight and
// keeps the {hi,lo} result in DONE until execute advances.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES,
    parameter int DIV_ITERS  = MD_DIV_ITERS
) (
    input logic     clk,
    input logic     resetn,
    muldiv_if.slave md
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    muldiv_op_t    op_q, mop;
    logic [31:0]   a_q, b_q, hi_q, hi_d, lo_q, lo_d, ma, mb, quo, rem, dvd, dvs;
    logic [63:0]   prod;
    logic          accept, is_mul, is_div, msgn, dsgn, qneg, rneg, busy;

    assign accept = state_q == ST_IDLE && md.valid && !md.flush;
    assign is_mul = md.op == MD_MULT || md.op == MD_MULTU;
    assign is_div = md.op == MD_DIV || md.op == MD_DIVU;

    // Live operands are only needed when a single-cycle multiply completes on its accept edge.
    assign mop  = state_q == ST_IDLE ? md.op : op_q;
    assign ma   = state_q == ST_IDLE ? md.a : a_q;
    assign mb   = state_q == ST_IDLE ? md.b : b_q;
    assign msgn = mop == MD_MULT;
    assign prod = $signed({{32{msgn & ma[31]}}, ma}) * $signed({{32{msgn & mb[31]}}, mb});

    // The core divides magnitudes; signs are reapplied in FIX from the latched operands.
    assign dsgn = md.op == MD_DIV;
    assign dvd  = dsgn && md.a[31] ? -md.a : md.a;
    assign dvs  = dsgn && md.b[31] ? -md.b : md.b;
    assign qneg = op_q == MD_DIV && (a_q[31] ^ b_q[31]);
    assign rneg = op_q == MD_DIV && a_q[31];

    div_core #(.ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept && is_div),
        .kill      (md.flush),
        .dividend  (dvd),
        .divisor   (dvs),
        .busy      (busy),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (md.flush) state_d = ST_IDLE;
        else case (state_q)
            ST_IDLE: if (md.valid && is_mul) begin
                state_d = MUL_CYCLES == 1 ? ST_DONE : ST_MUL;
                cnt_d   = CW'(MUL_CYCLES - 1);
                if (MUL_CYCLES == 1) {hi_d, lo_d} = prod;
            end else if (md.valid && is_div) state_d = ST_DIV;
            ST_MUL: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = ST_DONE;
                    {hi_d, lo_d} = prod;
                end
            end
            ST_DIV:  state_d = busy ? ST_DIV : ST_FIX;
            ST_FIX: begin
                state_d = ST_DONE;
                lo_d    = b_q == '0 ? '1 : qneg ? -quo : quo;
                hi_d    = b_q == '0 ? a_q : rneg ? -rem : rem;
            end
            ST_DONE: state_d = md.stall ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) begin
                op_q <= md.op;
                a_q  <= md.a;
                b_q  <= md.b;
            end
        end
    end

    assign md.ok = state_q == ST_DONE || (state_q == ST_IDLE && !md.valid);
    assign md.hi = hi_q;
    assign md.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit covering latency, signed/unsigned results,
// divide corner cases, flush, reset, stall hold and back-to-back issue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic     clk = 1'b0;
    logic     resetn = 1'b0;
    int       checks = 0;
    int       errors = 0;
    exp_t     sb[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    muldiv_if md ();

    muldiv_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (md)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_op(input string tag, input muldiv_op_t op, input logic [31:0] a, b, eh, el,
                         input int lat, input int hold);
        exp_t e;
        int   n;
        sb.push_back('{hi: eh, lo: el, lat: lat});
        md.valid = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        md.stall = hold > 0;
        n = 0;
        @(negedge clk);
        while (md.ok !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            md.a = $urandom;
            md.b = $urandom;
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, e.lat);
        end
        checks++;
        if (md.hi !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", tag, md.hi, e.hi);
        end
        checks++;
        if (md.lo !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", tag, md.lo, e.lo);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if ({md.ok, md.hi, md.lo} !== {1'b1, e.hi, e.lo}) begin
                errors++;
                $display("FAIL %s stall hold %0d: got ok=%b %h_%h want ok=1 %h_%h",
                         tag, i, md.ok, md.hi, md.lo, e.hi, e.lo);
            end
        end
        md.stall = 1'b0;
        @(posedge clk);
        #1;
        md.valid = 1'b0;
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] eh, el);
        checks++;
        if ({md.ok, md.hi, md.lo} !== {1'b1, eh, el}) begin
            errors++;
            $display("FAIL %s: got ok=%b %h_%h want ok=1 %h_%h", tag, md.ok, md.hi, md.lo, eh, el);
        end
    endtask

    task automatic test_reset();
        md.valid = 1'b0;
        md.op    = MD_NONE;
        md.a     = '0;
        md.b     = '0;
        md.stall = 1'b0;
        md.flush = 1'b0;
        resetn   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("reset idle", 32'h0, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        do_op("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2, 0);
        do_op("multu -3*7", MD_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 2, 0);
        do_op("mult -1*-1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 2, 0);
        do_op("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 2, 0);
    endtask

    task automatic test_div();
        do_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
        do_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0);
        do_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 0);
        do_op("div -7/-2", MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 34, 0);
    endtask

    task automatic test_div_edge();
        do_op("divu x/0", MD_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 34, 0);
        do_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 0);
        do_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, 0);
        do_op("divu max/1", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 34, 0);
    endtask

    task automatic test_flush();
        md.valid = 1'b1;
        md.op    = MD_DIV;
        md.a     = 32'd1000;
        md.b     = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        md.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (md.ok !== 1'b0) begin
            errors++;
            $display("FAIL flush busy ok: got %b want 0", md.ok);
        end
        @(posedge clk);
        #1;
        md.flush = 1'b0;
        md.valid = 1'b0;
        @(negedge clk);
        check_idle("flush idle", last_hi, last_lo);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_idle("flush late", last_hi, last_lo);
        @(posedge clk);
        #1;
        md.valid = 1'b1;
        md.op    = MD_MULT;
        md.a     = 32'd9;
        md.b     = 32'd9;
        md.flush = 1'b1;
        @(posedge clk);
        #1;
        md.flush = 1'b0;
        md.valid = 1'b0;
        @(negedge clk);
        check_idle("flush beats valid", last_hi, last_lo);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("flush no accept", last_hi, last_lo);
        @(posedge clk);
        #1;
        do_op("mult after flush", MD_MULT, 32'd5, 32'd6, 32'h0, 32'd30, 2, 0);
    endtask

    task automatic test_stall();
        do_op("multu stalled", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 2, 5);
        do_op("divu after stall", MD_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 34, 0);
        do_op("div stalled", MD_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 34, 3);
    endtask

    task automatic test_reset_mid();
        md.valid = 1'b1;
        md.op    = MD_DIVU;
        md.a     = 32'd77;
        md.b     = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        md.valid = 1'b0;
        @(negedge clk);
        check_idle("reset mid-op", 32'h0, 32'h0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_idle("reset op lost", 32'h0, 32'h0);
        @(posedge clk);
        #1;
        last_hi = '0;
        last_lo = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0]        a, b, eh, el;
        logic [63:0]        p;
        logic signed [63:0] sa, sb64;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                0: begin
                    p = 64'(a) * 64'(b);
                    do_op("b2b multu", MD_MULTU, a, b, p[63:32], p[31:0], 2, 0);
                end
                1: begin
                    sa   = $signed(a);
                    sb64 = $signed(b);
                    p    = sa * sb64;
                    do_op("b2b mult", MD_MULT, a, b, p[63:32], p[31:0], 2, 0);
                end
                2: begin
                    b  = (b >> $urandom_range(0, 31)) | 32'h1;
                    el = a / b;
                    eh = a % b;
                    do_op("b2b divu", MD_DIVU, a, b, eh, el, 34, 0);
                end
                default: begin
                    b  = 32'($urandom_range(1, 5000));
                    if ($urandom_range(0, 1) == 1) b = -b;
                    el = $signed(a) / $signed(b);
                    eh = $signed(a) % $signed(b);
                    do_op("b2b div", MD_DIV, a, b, eh, el, 34, 0);
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_edge();
        test_flush();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
